adder_sequencer: RTL and testbench

//  FSM that sequences operand entry for the switch-keyboard adder: captures

---
 rtl/adder_pkg.sv | 26 ++
 rtl/adder_sequencer_hold_timer.sv | 42 ++++
 rtl/adder_sequencer.sv | 134 +++++++++++++
 tb/tb_adder_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the switch-keyboard adder sequencer.
package adder_pkg;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    WAIT_SUM = 2'd2,
    SHOW     = 2'd3
  } state_e;

  localparam logic [2:0] MODE_A    = 3'b001;
  localparam logic [2:0] MODE_B    = 3'b010;
  localparam logic [2:0] MODE_SHOW = 3'b100;

  // WAIT_SUM shares the B indicator; unknown states fall back to A so mode is never zero.
  function automatic logic [2:0] mode_of(input state_e s);
    case (s)
      ENTER_A:  return MODE_A;
      ENTER_B:  return MODE_B;
      WAIT_SUM: return MODE_B;
      SHOW:     return MODE_SHOW;
      default:  return MODE_A;
    endcase
  endfunction

endpackage

// File: rtl/adder_sequencer_hold_timer.sv
// SHOW auto-return timer: counts from load, pulses expire on the last held cycle.
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  if (HOLD_CYCLES == 0) begin : g_disabled
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, load, enable};
    assign expire = 1'b0;
  end else begin : g_timer
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (load) begin
        cnt_d = '0;
      end else if (enable) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expire = enable && !load && (cnt_q == CNT_LAST);
  end

endmodule

// File: rtl/adder_sequencer.sv
// Operand entry sequencer: captures A then B from sw, waits for the adder
// to settle, registers the sum and selects what the 7-seg decoder shows.
module adder_sequencer
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned ADD_LAT     = 1,
  parameter int unsigned HOLD_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enter,
  input  logic             back,
  input  logic [WIDTH-1:0] sw,
  input  logic [WIDTH:0]   sum_in,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH:0]   disp_value,
  output logic [2:0]       mode,
  output logic             sum_valid,
  output logic             done
);

  // One cycle for op_b to reach the adder plus ADD_LAT+1 settle cycles.
  localparam int unsigned LAT_W = $clog2(ADD_LAT + 2);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ADD_LAT + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             sum_valid_q, sum_valid_d;
  logic             done_q, done_d;
  logic             enter_show;
  logic             hold_expire;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (enter_show),
    .enable (state_q == SHOW),
    .expire (hold_expire)
  );

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    sum_d      = sum_q;
    lat_cnt_d  = lat_cnt_q;
    enter_show = 1'b0;
    case (state_q)
      ENTER_A: begin
        if (enter) begin
          op_a_d  = sw;
          state_d = ENTER_B;
        end
      end
      ENTER_B: begin
        if (enter) begin
          op_b_d    = sw;
          lat_cnt_d = '0;
          state_d   = WAIT_SUM;
        end else if (back) begin
          state_d = ENTER_A;
        end
      end
      WAIT_SUM: begin
        if (lat_cnt_q == LAT_LAST) begin
          sum_d      = sum_in;
          state_d    = SHOW;
          enter_show = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (enter) begin
          state_d = ENTER_A;
        end else if (back) begin
          state_d = ENTER_B;
        end else if (hold_expire) begin
          state_d = ENTER_A;
        end
      end
      default: state_d = ENTER_A;
    endcase
    mode_d      = mode_of(state_d);
    sum_valid_d = (state_d == SHOW);
    done_d      = enter_show;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ENTER_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      lat_cnt_q   <= '0;
      mode_q      <= MODE_A;
      sum_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      lat_cnt_q   <= lat_cnt_d;
      mode_q      <= mode_d;
      sum_valid_q <= sum_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    disp_value = {1'b0, sw};
    case (state_q)
      WAIT_SUM: disp_value = {1'b0, op_b_q};
      SHOW:     disp_value = sum_q;
      default:  disp_value = {1'b0, sw};
    endcase
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign mode      = mode_q;
  assign sum_valid = sum_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: two instances (ADD_LAT=1/HOLD=0 and ADD_LAT=2/HOLD=10)
// share directed stimulus and are checked every cycle against a countdown model.
module tb_adder_sequencer;

  logic       clk;
  logic       rst;
  logic       enter;
  logic       back;
  logic [3:0] sw;

  logic [3:0] op_a0, op_b0, op_a1, op_b1;
  logic [4:0] sum_in0, sum_in1, disp0, disp1;
  logic [2:0] mode0, mode1;
  logic       sv0, sv1, done0, done1;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Adders driven from each DUT's operand outputs.
  assign sum_in0 = {1'b0, op_a0} + {1'b0, op_b0};
  assign sum_in1 = {1'b0, op_a1} + {1'b0, op_b1};

  adder_sequencer #(.WIDTH(4), .ADD_LAT(1), .HOLD_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .enter(enter), .back(back), .sw(sw), .sum_in(sum_in0),
    .op_a(op_a0), .op_b(op_b0), .disp_value(disp0), .mode(mode0),
    .sum_valid(sv0), .done(done0)
  );

  adder_sequencer #(.WIDTH(4), .ADD_LAT(2), .HOLD_CYCLES(10)) u1 (
    .clk(clk), .rst(rst), .enter(enter), .back(back), .sw(sw), .sum_in(sum_in1),
    .op_a(op_a1), .op_b(op_b1), .disp_value(disp1), .mode(mode1),
    .sum_valid(sv1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: phase plus countdowns of cycles left in WAIT and in SHOW.
  typedef enum {PH_A, PH_B, PH_WAIT, PH_SHOW} phase_t;
  int     lat_p [2] = '{1, 2};
  int     hold_p[2] = '{0, 10};
  phase_t ph [2] = '{PH_A, PH_A};
  int     ma [2] = '{0, 0};
  int     mb [2] = '{0, 0};
  int     ms [2] = '{0, 0};
  int     left[2] = '{0, 0};
  bit     mdone[2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ph[i] = PH_A; ma[i] = 0; mb[i] = 0; ms[i] = 0; left[i] = 0; mdone[i] = 0;
      end else begin
        mdone[i] = 0;
        case (ph[i])
          PH_A: if (enter) begin ma[i] = sw; ph[i] = PH_B; end
          PH_B: begin
            if (enter) begin mb[i] = sw; ph[i] = PH_WAIT; left[i] = lat_p[i] + 2; end
            else if (back) ph[i] = PH_A;
          end
          PH_WAIT: begin
            left[i]--;
            if (left[i] == 0) begin
              ms[i] = ma[i] + mb[i]; ph[i] = PH_SHOW; mdone[i] = 1; left[i] = hold_p[i];
            end
          end
          PH_SHOW: begin
            if (enter) ph[i] = PH_A;
            else if (back) ph[i] = PH_B;
            else if (hold_p[i] > 0) begin
              left[i]--;
              if (left[i] == 0) ph[i] = PH_A;
            end
          end
        endcase
      end
    end
  end

  function automatic int exp_mode(input int i);
    case (ph[i])
      PH_A:    return 1;
      PH_SHOW: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int exp_disp(input int i);
    case (ph[i])
      PH_WAIT: return mb[i];
      PH_SHOW: return ms[i];
      default: return int'(sw);
    endcase
  endfunction

  always @(negedge clk) begin
    chk("u0.op_a", op_a0, ma[0]);
    chk("u0.op_b", op_b0, mb[0]);
    chk("u0.disp", disp0, exp_disp(0));
    chk("u0.mode", mode0, exp_mode(0));
    chk("u0.sum_valid", sv0, int'(ph[0] == PH_SHOW));
    chk("u0.done", done0, int'(mdone[0]));
    chk("u1.op_a", op_a1, ma[1]);
    chk("u1.op_b", op_b1, mb[1]);
    chk("u1.disp", disp1, exp_disp(1));
    chk("u1.mode", mode1, exp_mode(1));
    chk("u1.sum_valid", sv1, int'(ph[1] == PH_SHOW));
    chk("u1.done", done1, int'(mdone[1]));
  end

  task automatic step(input logic e, input logic b, input logic [3:0] s);
    enter = e; back = b; sw = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enter = 1'b0; back = 1'b0; sw = '0;
    #3;
    chk("lit.reset_mode", mode0, 1);
    chk("lit.reset_sum_valid", sv0, 0);
    chk("lit.reset_done", done0, 0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // 9 + 8: SHOW three edges after B is accepted.
    step(1, 0, 9);
    step(1, 0, 8);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("lit.sum17", disp0, 17);
    chk("lit.sum17_mode", mode0, 4);
    chk("lit.sum17_valid", sv0, 1);
    chk("lit.sum17_done", done0, 1);
    chk("lit.sum17_ops", {op_a0, op_b0}, {4'd9, 4'd8});
    step(0, 0, 0);
    chk("lit.done_once", done0, 0);

    // 15 + 15 with enter/back pokes during WAIT_SUM.
    step(1, 0, 0);
    step(1, 0, 15);
    step(1, 0, 15);
    step(1, 0, 3); step(0, 1, 3); step(1, 1, 3);
    chk("lit.sum30", disp0, 30);
    chk("lit.sum30_b", op_b0, 15);
    step(0, 0, 0);

    // 0 + 0.
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("lit.sum0", disp0, 0);
    chk("lit.sum0_mode", mode0, 4);

    // Back from ENTER_B, then re-entry overwrites A.
    step(1, 0, 0);
    step(1, 0, 5);
    step(0, 1, 0);
    chk("lit.back_mode", mode0, 1);
    chk("lit.back_keep_a", op_a0, 5);
    step(1, 0, 3);
    chk("lit.reenter_a", op_a0, 3);
    step(1, 0, 4);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("lit.sum7", disp0, 7);
    step(0, 1, 0);
    chk("lit.show_back", mode0, 2);
    step(1, 0, 2);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("lit.sum5", disp0, 5);
    step(1, 1, 0);
    chk("lit.enter_wins", mode0, 1);

    // Async reset in the middle of WAIT_SUM.
    step(1, 0, 6);
    step(1, 0, 6);
    enter = 1'b0; sw = '0;
    #2 rst = 1'b1;
    #1;
    chk("lit.rst_mode", mode0, 1);
    chk("lit.rst_valid", sv0, 0);
    chk("lit.rst_ops", {op_a0, op_b0, op_a1, op_b1}, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Hold timeout on u1; u0 must stay in SHOW.
    step(1, 0, 2);
    step(1, 0, 3);
    for (int n = 0; n < 10 && !done1; n++) step(0, 0, 0);
    chk("lit.hold_done_seen", done1, 1);
    for (int n = 0; n < 9; n++) step(0, 0, 0);
    chk("lit.hold_still_show", mode1, 4);
    step(0, 0, 0);
    chk("lit.hold_expired", mode1, 1);
    for (int n = 0; n < 1000; n++) step(0, 0, 0);
    chk("lit.no_hold_mode", mode0, 4);
    chk("lit.no_hold_disp", disp0, 5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
